// File: rtl/j1_io_pkg.sv
// j1_io_pkg: shared types and constants for the J1 I/O fabric.
//   - state_t       : fabric FSM states
//   - STAT_*        : offsets inside the fabric status page
//   - FLAG_*        : bit positions of the sticky error flags
//   - ABORT_DATA    : read data returned when an access is aborted by the watchdog
//   - status_word() : read value of a status-page offset
package j1_io_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   localparam logic [7:0]  STAT_FLAGS    = 8'd0;
   localparam logic [7:0]  STAT_ERRADDR  = 8'd1;

   localparam int          FLAG_UNMAPPED = 0;
   localparam int          FLAG_TIMEOUT  = 1;

   localparam logic [15:0] ABORT_DATA    = 16'hDEAD;

   // Slot index is sized for the largest supported slot count (8).
   localparam int          SLOT_IDX_W    = 3;

   function automatic logic [15:0] status_word(input logic [7:0]  offset,
                                               input logic [1:0]  flags,
                                               input logic [15:0] err_addr);
      logic [15:0] val;
      val = 16'h0000;
      if (offset == STAT_FLAGS)
         val = {14'b0, flags};
      else if (offset == STAT_ERRADDR)
         val = err_addr;
      return val;
   endfunction

endpackage

// File: rtl/j1_io_fabric_if.sv
// j1_io_fabric_if: J1 I/O bus plus peripheral-slot bus of the I/O fabric.
//   CPU side : cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_dout_i -> fabric
//              cpu_din_o, cpu_stall_o                    <- fabric
//   Slot side: per_cs_o, per_rd_o, per_wr_o, per_addr_o, per_dout_o <- fabric
//              per_din_i, per_ack_i                                -> fabric
// Modports: master = CPU/peripheral environment, slave = the fabric.
interface j1_io_fabric_if #(
   parameter int NSLOTS = 4
);
   logic                   cpu_rd_i;
   logic                   cpu_wr_i;
   logic [15:0]            cpu_addr_i;
   logic [15:0]            cpu_dout_i;
   logic [15:0]            cpu_din_o;
   logic                   cpu_stall_o;

   logic [NSLOTS-1:0]      per_cs_o;
   logic                   per_rd_o;
   logic                   per_wr_o;
   logic [7:0]             per_addr_o;
   logic [15:0]            per_dout_o;
   logic [NSLOTS*16-1:0]   per_din_i;
   logic [NSLOTS-1:0]      per_ack_i;

   modport master (
      output cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_dout_i, per_din_i, per_ack_i,
      input  cpu_din_o, cpu_stall_o, per_cs_o, per_rd_o, per_wr_o, per_addr_o, per_dout_o
   );

   modport slave (
      input  cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_dout_i, per_din_i, per_ack_i,
      output cpu_din_o, cpu_stall_o, per_cs_o, per_rd_o, per_wr_o, per_addr_o, per_dout_o
   );
endinterface

// File: rtl/j1_io_decode.sv
// j1_io_decode: combinational page decoder of the I/O fabric.
//   page       in  : address page [15:8]
//   hit        out : one-hot slot select (lowest matching slot only)
//   idx        out : index of the selected slot
//   status_hit out : page is the fabric status page
//   slot_hit   out : some slot matches (and the status page does not)
//   unmapped   out : neither status page nor any slot
module j1_io_decode
   import j1_io_pkg::*;
#(
   parameter int                  NSLOTS      = 4,
   parameter logic [NSLOTS*8-1:0] SLOT_PAGE   = {8'h99, 8'h74, 8'h69, 8'h67},
   parameter logic [7:0]          STATUS_PAGE = 8'hF0
) (
   input  logic [7:0]            page,
   output logic [NSLOTS-1:0]     hit,
   output logic [SLOT_IDX_W-1:0] idx,
   output logic                  status_hit,
   output logic                  slot_hit,
   output logic                  unmapped
);

   always_comb begin
      hit        = '0;
      idx        = '0;
      slot_hit   = 1'b0;
      status_hit = (page == STATUS_PAGE);
      // Scan from the top down so the lowest matching index is the one left standing.
      if (!status_hit) begin
         for (int k = NSLOTS - 1; k >= 0; k--) begin
            if (page == SLOT_PAGE[8*k +: 8]) begin
               hit      = '0;
               hit[k]   = 1'b1;
               idx      = SLOT_IDX_W'(k);
               slot_hit = 1'b1;
            end
         end
      end
      unmapped = !status_hit && !slot_hit;
   end

endmodule

// File: rtl/j1_io_fabric.sv
// j1_io_fabric: I/O interconnect between the J1 I/O bus and NSLOTS peripheral slots.
//   sys_clk_i : system clock
//   sys_rst_i : asynchronous active-low reset
//   bus       : j1_io_fabric_if.slave (CPU request/response, slot selects/strobes/data/ack)
// Slot accesses go IDLE -> ACCESS -> DONE with the CPU stalled until DONE.
// Status-page and unmapped accesses complete in IDLE without a stall.
module j1_io_fabric
   import j1_io_pkg::*;
#(
   parameter int                  NSLOTS      = 4,
   parameter logic [NSLOTS*8-1:0] SLOT_PAGE   = {8'h99, 8'h74, 8'h69, 8'h67},
   parameter logic [NSLOTS-1:0]   SLOT_ACK    = '0,
   parameter logic [7:0]          STATUS_PAGE = 8'hF0,
   parameter int                  TIMEOUT     = 15
) (
   input logic           sys_clk_i,
   input logic           sys_rst_i,
   j1_io_fabric_if.slave bus
);

   state_t                  state;
   logic [15:0]             rdata;
   logic [15:0]             cap_addr;
   logic                    cap_wr;
   logic [SLOT_IDX_W-1:0]   cap_idx;
   logic [7:0]              cnt;
   logic [1:0]              flags;
   logic [15:0]             err_addr;

   logic                    req, is_wr, is_rd, idle;
   logic [NSLOTS-1:0]       dec_hit;
   logic [SLOT_IDX_W-1:0]   dec_idx;
   logic                    dec_status, dec_slot, dec_unmapped;
   logic                    ack_mode, ack_seen, access_end, abort;
   logic [15:0]             din_sel;
   logic [1:0]              flag_set, flag_clr;

   // A simultaneous read and write is a write.
   assign req   = bus.cpu_rd_i | bus.cpu_wr_i;
   assign is_wr = bus.cpu_wr_i;
   assign is_rd = bus.cpu_rd_i & ~bus.cpu_wr_i;
   assign idle  = (state == S_IDLE);

   j1_io_decode #(
      .NSLOTS      (NSLOTS),
      .SLOT_PAGE   (SLOT_PAGE),
      .STATUS_PAGE (STATUS_PAGE)
   ) u_decode (
      .page       (bus.cpu_addr_i[15:8]),
      .hit        (dec_hit),
      .idx        (dec_idx),
      .status_hit (dec_status),
      .slot_hit   (dec_slot),
      .unmapped   (dec_unmapped)
   );

   // The registered chip select doubles as the "current slot" mask, so acks
   // from other slots, or after an abort has dropped the select, are ignored.
   assign ack_mode = |(SLOT_ACK & bus.per_cs_o);
   assign ack_seen = |(bus.per_ack_i & bus.per_cs_o);

   assign access_end = (state == S_ACCESS) && (!ack_mode || ack_seen);
   assign abort      = (state == S_ACCESS) && ack_mode && !ack_seen &&
                       (cnt == 8'(TIMEOUT - 1));

   always_comb begin
      din_sel = 16'h0000;
      for (int k = 0; k < NSLOTS; k++) begin
         if (cap_idx == SLOT_IDX_W'(k))
            din_sel = bus.per_din_i[16*k +: 16];
      end
   end

   // Sticky error flags: clear by write-1 at STAT_FLAGS, set by error events; set wins.
   always_comb begin
      flag_set = 2'b00;
      flag_clr = 2'b00;
      if (idle && req && dec_status && is_wr && bus.cpu_addr_i[7:0] == STAT_FLAGS)
         flag_clr = bus.cpu_dout_i[1:0];
      if (idle && req && dec_unmapped)
         flag_set[FLAG_UNMAPPED] = 1'b1;
      if (abort)
         flag_set[FLAG_TIMEOUT] = 1'b1;
   end

   // Stall is forced low while reset is held so the CPU sees reset values at once.
   assign bus.cpu_stall_o = sys_rst_i && ((idle && req && dec_slot) || state == S_ACCESS);

   always_comb begin
      bus.cpu_din_o = rdata;
      if (idle && is_rd && dec_status)
         bus.cpu_din_o = status_word(bus.cpu_addr_i[7:0], flags, err_addr);
      else if (idle && is_rd && dec_unmapped)
         bus.cpu_din_o = 16'h0000;
   end

   assign bus.per_addr_o = cap_addr[7:0];

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         state          <= S_IDLE;
         rdata          <= 16'h0000;
         cap_addr       <= 16'h0000;
         cap_wr         <= 1'b0;
         cap_idx        <= '0;
         cnt            <= 8'd0;
         flags          <= 2'b00;
         err_addr       <= 16'h0000;
         bus.per_cs_o   <= '0;
         bus.per_rd_o   <= 1'b0;
         bus.per_wr_o   <= 1'b0;
         bus.per_dout_o <= 16'h0000;
      end else begin
         bus.per_rd_o <= 1'b0;
         bus.per_wr_o <= 1'b0;
         flags        <= (flags & ~flag_clr) | flag_set;

         case (state)
            S_IDLE: begin
               if (req && dec_slot) begin
                  state          <= S_ACCESS;
                  bus.per_cs_o   <= dec_hit;
                  bus.per_rd_o   <= ~is_wr;
                  bus.per_wr_o   <= is_wr;
                  bus.per_dout_o <= bus.cpu_dout_i;
                  cap_addr       <= bus.cpu_addr_i;
                  cap_wr         <= is_wr;
                  cap_idx        <= dec_idx;
                  cnt            <= 8'd0;
               end else if (req && dec_unmapped) begin
                  err_addr <= bus.cpu_addr_i;
               end
            end

            S_ACCESS: begin
               cnt <= cnt + 8'd1;
               if (access_end) begin
                  if (!cap_wr)
                     rdata <= din_sel;
                  bus.per_cs_o <= '0;
                  state        <= S_DONE;
               end else if (abort) begin
                  rdata        <= ABORT_DATA;
                  err_addr     <= cap_addr;
                  bus.per_cs_o <= '0;
                  state        <= S_DONE;
               end
            end

            // The CPU's still-held request completes here; it is not decoded again.
            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_j1_io_fabric.sv
// tb_j1_io_fabric: scoreboard bench for j1_io_fabric.
// Stimulus pushes expected completions and strobes into queues; two monitors
// on the falling edge pop and compare when the DUT completes or strobes.
module tb_j1_io_fabric;

   typedef struct {
      int          cyc;
      logic        chk;
      logic [15:0] data;
   } cpl_t;

   typedef struct {
      int          cyc;
      logic [3:0]  cs;
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] dout;
   } stb_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   cpl_t cpl_q[$];
   stb_t stb_q[$];
   cpl_t ce;
   stb_t se;

   j1_io_fabric_if #(.NSLOTS(4)) bus ();

   j1_io_fabric #(
      .NSLOTS      (4),
      .SLOT_PAGE   ({8'h99, 8'h74, 8'h69, 8'h67}),
      .SLOT_ACK    (4'b0001),
      .STATUS_PAGE (8'hF0),
      .TIMEOUT     (15)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Completion monitor: a held request with stall low is the CPU seeing its answer.
   always @(negedge clk) begin
      if (rst_n && (bus.cpu_rd_i || bus.cpu_wr_i) && !bus.cpu_stall_o) begin
         if (cpl_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_completion: got din %h at cycle %0d, want none", bus.cpu_din_o, cyc);
         end else begin
            ce = cpl_q.pop_front();
            check("cpl_cycle", 48'(cyc), 48'(ce.cyc));
            if (ce.chk)
               check("cpl_data", 48'(bus.cpu_din_o), 48'(ce.data));
         end
      end
   end

   // Strobe monitor: every rd/wr pulse must match one queued expectation.
   always @(negedge clk) begin
      if (bus.per_rd_o || bus.per_wr_o) begin
         if (stb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got rd=%b wr=%b cs=%b at cycle %0d, want none",
                     bus.per_rd_o, bus.per_wr_o, bus.per_cs_o, cyc);
         end else begin
            se = stb_q.pop_front();
            check("stb_cycle", 48'(cyc), 48'(se.cyc));
            check("stb_fields",
                  {14'b0, bus.per_cs_o, bus.per_rd_o, bus.per_wr_o, bus.per_addr_o, bus.per_dout_o},
                  {14'b0, se.cs, se.rd, se.wr, se.addr, se.dout});
         end
      end
   end

   // Issues one request in the current cycle (entered just after a rising edge) and
   // holds it until stall drops. lat = completion cycle offset; exp_cs = 0 means no slot
   // access (no strobe expected). An ack of ack_val is driven in cycle T+ack_off.
   task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] dout, input int lat, input logic chk,
                         input logic [15:0] exp, input logic [3:0] exp_cs,
                         input int ack_off, input logic [3:0] ack_val);
      int  t;
      bit  done;
      t = cyc;
      done = 0;
      bus.cpu_rd_i   = rd;
      bus.cpu_wr_i   = wr;
      bus.cpu_addr_i = addr;
      bus.cpu_dout_i = dout;
      cpl_q.push_back(cpl_t'{t + lat, chk, exp});
      if (exp_cs != 4'b0000)
         stb_q.push_back(stb_t'{t + 1, exp_cs, rd && !wr, wr, addr[7:0], dout});
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.cpu_stall_o) begin
            done = 1;
            break;
         end
         if (cyc > t)
            check("access_hold", {12'b0, bus.per_cs_o, bus.per_addr_o, bus.per_dout_o},
                  {12'b0, exp_cs, addr[7:0], dout});
         @(posedge clk);
         #1;
         bus.per_ack_i = (ack_off > 0 && cyc == t + ack_off) ? ack_val : 4'b0000;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL stall_bound: got stall still high after 40 cycles, want completion (addr %h)", addr);
      end
      @(posedge clk);
      #1;
      bus.cpu_rd_i  = 1'b0;
      bus.cpu_wr_i  = 1'b0;
      bus.per_ack_i = 4'b0000;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {bus.cpu_din_o, bus.per_dout_o, 4'b0, bus.per_cs_o, bus.per_addr_o},
            48'h0);
      check({name, "_ctl"}, {45'b0, bus.per_rd_o, bus.per_wr_o, bus.cpu_stall_o}, 48'h0);
   endtask

   initial begin
      int t;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.cpu_rd_i   = 1'b0;
      bus.cpu_wr_i   = 1'b0;
      bus.cpu_addr_i = 16'h0000;
      bus.cpu_dout_i = 16'h0000;
      bus.per_ack_i  = 4'b0000;
      bus.per_din_i  = {16'h1234, 16'hBEEF, 16'h0F0F, 16'h5A5A};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;

      // First request accepted in the first IDLE cycle after release.
      access(1, 0, 16'h9904, 16'h0000, 2, 1, 16'h1234, 4'b1000, 0, 4'b0000);
      access(1, 0, 16'h7410, 16'h0000, 2, 1, 16'hBEEF, 4'b0100, 0, 4'b0000);
      // Ack-mode write: ack at T+4 -> DONE T+5; a write leaves read data untouched.
      access(0, 1, 16'h6702, 16'hA5A5, 5, 1, 16'hBEEF, 4'b0001, 4, 4'b0001);
      // Ack-mode read, ack in the first ACCESS cycle.
      access(1, 0, 16'h6710, 16'h0000, 2, 1, 16'h5A5A, 4'b0001, 1, 4'b0001);
      // Never acked (a foreign-slot ack is ignored) -> watchdog abort at T+16.
      access(1, 0, 16'h6733, 16'h0000, 16, 1, 16'hDEAD, 4'b0001, 5, 4'b0010);
      access(1, 0, 16'hF000, 16'h0000, 0, 1, 16'h0002, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF001, 16'h0000, 0, 1, 16'h6733, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF007, 16'h0000, 0, 1, 16'h0000, 4'b0000, 0, 4'b0000);
      // Unmapped read: no stall, zero data, flag and error address captured.
      access(1, 0, 16'h1234, 16'h0000, 0, 1, 16'h0000, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF000, 16'h0000, 0, 1, 16'h0003, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF001, 16'h0000, 0, 1, 16'h1234, 4'b0000, 0, 4'b0000);
      // Write-1-to-clear, one flag at a time; write completion shows held rdata.
      access(0, 1, 16'hF000, 16'h0001, 0, 1, 16'hDEAD, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF000, 16'h0000, 0, 1, 16'h0002, 4'b0000, 0, 4'b0000);
      access(0, 1, 16'hF000, 16'h0002, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF000, 16'h0000, 0, 1, 16'h0000, 4'b0000, 0, 4'b0000);
      // rd+wr together is a write; the back-to-back read follows the DONE cycle.
      access(1, 1, 16'h6905, 16'hC3C3, 2, 1, 16'hDEAD, 4'b0010, 0, 4'b0000);
      access(1, 0, 16'h9900, 16'h0000, 2, 1, 16'h1234, 4'b1000, 0, 4'b0000);
      // Leave a flag and error address set so reset has something to clear.
      access(1, 0, 16'h2222, 16'h0000, 0, 1, 16'h0000, 4'b0000, 0, 4'b0000);

      // Reset in the middle of an ack-mode access.
      t = cyc;
      bus.cpu_rd_i   = 1'b1;
      bus.cpu_addr_i = 16'h6755;
      bus.cpu_dout_i = 16'h7777;
      stb_q.push_back(stb_t'{t + 1, 4'b0001, 1'b1, 1'b0, 8'h55, 16'h7777});
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("pre_reset_cs", 48'(bus.per_cs_o), 48'(4'b0001));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_access_reset");
      bus.cpu_rd_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      access(1, 0, 16'hF000, 16'h0000, 0, 1, 16'h0000, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'hF001, 16'h0000, 0, 1, 16'h0000, 4'b0000, 0, 4'b0000);
      access(1, 0, 16'h9904, 16'h0000, 2, 1, 16'h1234, 4'b1000, 0, 4'b0000);

      repeat (3) @(posedge clk);
      #1;
      check("cpl_queue_drained", 48'(cpl_q.size()), 48'h0);
      check("stb_queue_drained", 48'(stb_q.size()), 48'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test by 200000, want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/j1_io_fabric.md
# j1_io_fabric

Parametrised I/O interconnect between the J1 core's I/O bus and up to NSLOTS peripheral slots. It replaces the fixed page decoder and read multiplexer in the SoC top with:
- registered per-slot chip selects and strobes;
- per-slot fixed-latency or acknowledge-based completion, with a stall to the CPU;
- a timeout watchdog;
- a built-in status page recording bus errors.

## Interface
Parameters:
- NSLOTS, 4, number of peripheral slots (1..8)
- SLOT_PAGE, {8'h99,8'h74,8'h69,8'h67}, NSLOTS×8 packed; page of slot k in bits [8k+7:8k]
- SLOT_ACK, 4'b0000, per-slot mode: 0 = fixed one-cycle response, 1 = wait for per_ack_i[k]
- STATUS_PAGE, 8'hF0, page of the fabric status registers
- TIMEOUT, 15, maximum ACCESS cycles an ack-mode slot may take (1..255)

Ports:
- sys_clk_i  in  1  system clock
- sys_rst_i  in  1  reset, asynchronous, active-low
- cpu_rd_i  in  1  J1 I/O read request
- cpu_wr_i  in  1  J1 I/O write request
- cpu_addr_i  in  16  J1 I/O address; [15:8] page, [7:0] offset
- cpu_dout_i  in  16  J1 write data
- cpu_din_o  out  16  read data to J1
- cpu_stall_o  out  1  CPU must hold its request while high
- per_cs_o  out  NSLOTS  one-hot slot select
- per_rd_o  out  1  one-cycle read strobe
- per_wr_o  out  1  one-cycle write strobe
- per_addr_o  out  8  captured offset
- per_dout_o  out  16  captured write data
- per_din_i  in  NSLOTS×16  slot read data; slot k in bits [16k+15:16k]
- per_ack_i  in  NSLOTS  completion from ack-mode slots

## Operation
FSM states: IDLE, ACCESS, DONE.

IDLE:
- A request is cpu_rd_i or cpu_wr_i. If both are asserted, it is treated as a write.
- Decode priority: STATUS_PAGE first, then the lowest-index slot whose page matches, otherwise unmapped.
- Slot hit: capture slot index, offset, write data and direction, then go to ACCESS.
- Status page: serviced in the same cycle with no stall. The state stays IDLE.
  - Read offset 0 returns {14'b0, timeout_flag, unmapped_flag}.
  - Read offset 1 returns err_addr.
  - Any other offset returns 0.
  - Write to offset 0 clears each flag whose cpu_dout_i bit is 1 (write-1-to-clear).
- Unmapped: no strobe, no stall. A read returns 16'h0000 in the same cycle. The access sets unmapped_flag and loads err_addr with cpu_addr_i.

ACCESS:
- per_cs_o[k] is held high throughout.
- per_rd_o or per_wr_o is high only in the first ACCESS cycle.
- Fixed-mode slot: per_din_i[k] is captured into rdata at the end of the first cycle, then go to DONE.
- Ack-mode slot: per_ack_i[k] is sampled every ACCESS cycle. Reads capture per_din_i[k] in the cycle ack is seen, then go to DONE.
- Watchdog: the counter counts ACCESS cycles. If TIMEOUT cycles pass with no ack:
  - rdata is loaded with 16'hDEAD;
  - timeout_flag is set and err_addr is loaded;
  - the FSM goes to DONE.
- Ack from a non-selected slot, or any ack after a timeout abort, is ignored.

DONE:
- Selects and strobes are low, stall is low, and cpu_din_o presents rdata.
- Request inputs are ignored in this cycle. The CPU's still-held request is the completing one.
- Return to IDLE next cycle.

Other rules:
- cpu_stall_o = (IDLE and request decoding to a slot) or ACCESS. It is combinational from the request in IDLE.
- cpu_din_o is rdata, except during an IDLE status/unmapped read, when it carries the combinational status/zero value. rdata holds its last value otherwise.
- Writes never alter rdata.
- If a status-page write and an error event occur in the same cycle, the set wins.

## Timing
- Request at cycle T into a fixed-mode slot:
  - T+1: ACCESS with strobe.
  - T+2: DONE with data.
  - Stall is high during T and T+1.
- Ack-mode slot with ack at T+1+n: DONE at T+2+n, stall high T..T+1+n.
- Timeout: DONE at T+1+TIMEOUT.
- Reset values (sys_rst_i low, asynchronous, effective mid-transfer):
  - state IDLE;
  - cpu_din_o, rdata, per_addr_o, per_dout_o, err_addr = 0;
  - per_cs_o, per_rd_o, per_wr_o, cpu_stall_o, flags, counter = 0.
- The first request after reset release is accepted in the first IDLE cycle.

## Structure
- Package j1_io_pkg holds:
  - the state enum;
  - the status offsets STAT_FLAGS=0 and STAT_ERRADDR=1;
  - flag bit positions;
  - the abort value 16'hDEAD.
- Sub-module j1_io_decode is combinational: page plus SLOT_PAGE/STATUS_PAGE in, one-hot hit, slot index, status-hit and unmapped out.
- The top level holds the FSM, watchdog, capture registers and status registers.

## Test plan
- Fixed slot, page 8'h99 at k=3: read addr 16'h9904 with per_din_i[3]=16'h1234. Expected: per_cs_o=4'b1000 and per_rd_o for one cycle at T+1, stall high T and T+1, cpu_din_o=16'h1234 at T+2.
- Ack slot (SLOT_ACK[0]=1): write 16'hA5A5 to 16'h6702, ack at T+4. Expected: per_wr_o only at T+1, per_dout_o=16'hA5A5 and per_addr_o=8'h02 held through T+4, DONE at T+5.
- Ack slot never acks, TIMEOUT=15. Expected: DONE at T+16, cpu_din_o=16'hDEAD, a read of 16'hF000 returns 16'h0002, a read of 16'hF001 returns the faulting address.
- Unmapped read of 16'h1234. Expected: no stall, cpu_din_o=0, unmapped_flag set. Then write 16'h0001 to 16'hF000: flag clears, and a subsequent read returns 0.
- Simultaneous rd+wr to a slot. Expected: only per_wr_o pulses. A request held through DONE is not reissued; a new request in the next IDLE cycle is accepted.
- Assert sys_rst_i low mid-ACCESS. Expected: outputs immediately at reset values. After release, a fixed-slot read completes normally at T+2.
